// File: rtl/oam_dma_master_if.sv
// CPU-side and bus-side signal bundle for the NES sprite DMA master.
// master = the DMA block, slave = the CPU/bus-mux side feeding it.
interface oam_dma_master_if;
   logic        i_cpu_ce;
   logic [15:0] i_cpu_addr;
   logic        i_cpu_rnw;
   logic [7:0]  i_cpu_data_out;
   logic [7:0]  i_bus_data_in;
   logic        o_cpu_rdy;
   logic        o_bus_own;
   logic [15:0] o_bus_addr;
   logic        o_bus_rnw;
   logic [7:0]  o_bus_data_out;
   logic        o_dma_active;
   logic        o_done;

   modport master (
      input  i_cpu_ce,
      input  i_cpu_addr,
      input  i_cpu_rnw,
      input  i_cpu_data_out,
      input  i_bus_data_in,
      output o_cpu_rdy,
      output o_bus_own,
      output o_bus_addr,
      output o_bus_rnw,
      output o_bus_data_out,
      output o_dma_active,
      output o_done
   );

   modport slave (
      output i_cpu_ce,
      output i_cpu_addr,
      output i_cpu_rnw,
      output i_cpu_data_out,
      output i_bus_data_in,
      input  o_cpu_rdy,
      input  o_bus_own,
      input  o_bus_addr,
      input  o_bus_rnw,
      input  o_bus_data_out,
      input  o_dma_active,
      input  o_done
   );
endinterface

// File: rtl/oam_dma_master.sv
// NES $4014 sprite DMA: halts the CPU, then copies one 256-byte
// page to $2004 as alternating get/put read/write pairs.
module oam_dma_master #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   oam_dma_master_if.master  dma
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] index_q, index_d;
   logic [7:0] data_q, data_d;
   logic       parity_q, parity_d;
   logic       done_q, done_d;
   logic       trig;

   assign trig = (dma.i_cpu_addr == DMA_REG_ADDR) && !dma.i_cpu_rnw;

   // Next-state logic; every transition is gated by the CPU cycle enable.
   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      index_d  = index_q;
      data_d   = data_q;
      parity_d = parity_q;
      done_d   = 1'b0;
      if (dma.i_cpu_ce) begin
         parity_d = ~parity_q;
         unique case (state_q)
            S_IDLE: begin
               if (trig) begin
                  page_d  = dma.i_cpu_data_out;
                  index_d = 8'h00;
                  state_d = S_HALT;
               end
            end
            S_HALT: begin
               // parity 1 now means the next cycle is a get cycle
               state_d = parity_q ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
               state_d = S_READ;
            end
            S_READ: begin
               data_d  = dma.i_bus_data_in;
               state_d = S_WRITE;
            end
            S_WRITE: begin
               if (index_q == 8'hFF) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  index_d = index_q + 8'd1;
                  state_d = S_READ;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= S_IDLE;
         page_q   <= 8'h00;
         index_q  <= 8'h00;
         data_q   <= 8'h00;
         parity_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         index_q  <= index_d;
         data_q   <= data_d;
         parity_q <= parity_d;
         done_q   <= done_d;
      end
   end

   // Bus outputs decoded from registered state only.
   always_comb begin
      dma.o_cpu_rdy      = 1'b1;
      dma.o_bus_own      = 1'b0;
      dma.o_bus_addr     = 16'h0000;
      dma.o_bus_rnw      = 1'b1;
      dma.o_bus_data_out = 8'h00;
      dma.o_dma_active   = 1'b0;
      dma.o_done         = done_q;
      unique case (state_q)
         S_IDLE: begin
         end
         S_HALT, S_ALIGN: begin
            dma.o_cpu_rdy    = 1'b0;
            dma.o_dma_active = 1'b1;
         end
         S_READ: begin
            dma.o_cpu_rdy    = 1'b0;
            dma.o_dma_active = 1'b1;
            dma.o_bus_own    = 1'b1;
            dma.o_bus_addr   = {page_q, index_q};
         end
         S_WRITE: begin
            dma.o_cpu_rdy      = 1'b0;
            dma.o_dma_active   = 1'b1;
            dma.o_bus_own      = 1'b1;
            dma.o_bus_addr     = OAM_DATA_ADDR;
            dma.o_bus_rnw      = 1'b0;
            dma.o_bus_data_out = data_q;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/oam_dma_master.md
Name: oam_dma_master

Overview:
- CPU-bus initiator for NES sprite DMA.
- A CPU write to $4014 latches a source page. The block then halts the CPU via RDY and takes ownership of the CPU bus.
- It performs 256 read/write pairs: read from {page, index}, then write to $2004, through the existing bus decode unit.
- Its bus outputs are muxed in front of the bus decode unit whenever o_bus_own is high.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_cpu_ce  in  1  one-clock pulse per CPU cycle; all state advances only when high
- i_cpu_addr  in  16  CPU-driven address, used for trigger detect
- i_cpu_rnw  in  1  CPU read/not-write
- i_cpu_data_out  in  8  CPU write data, giving the page number on trigger
- i_bus_data_in  in  8  read data returned by the bus decode mux
- o_cpu_rdy  out  1  low means the CPU core must stall
- o_bus_own  out  1  high means the bus mux selects this block's address/rnw/data
- o_bus_addr  out  16  DMA bus address
- o_bus_rnw  out  1  DMA read/not-write
- o_bus_data_out  out  8  DMA write data
- o_dma_active  out  1  high from HALT through the last WRITE
- o_done  out  1  single-clock pulse on the i_cpu_ce that completes the last WRITE

Behaviour:
- Reset: asynchronous, active-low. Asserting i_reset_n low, including mid-DMA, forces the following values immediately.
  - state=IDLE, page=0, index=0, data latch=0, parity=0.
  - o_cpu_rdy=1, o_bus_own=0, o_bus_addr=0, o_bus_rnw=1, o_bus_data_out=0, o_dma_active=0, o_done=0.
- Parity flop:
  - Toggles on every i_cpu_ce.
  - 0 = get cycle, 1 = put cycle.
  - Free-runs in all states.
- Trigger: in IDLE, on i_cpu_ce with i_cpu_addr==DMA_REG_ADDR and i_cpu_rnw==0:
  - latch page = i_cpu_data_out;
  - clear index;
  - go to HALT.
- Triggers outside IDLE are ignored; the page is not updated.
- States (transitions only on i_cpu_ce):
  - IDLE: as above.
  - HALT: one CPU cycle, no bus access.
    - Next state is READ if the following cycle is a get cycle (current parity=1); otherwise ALIGN.
  - ALIGN: one dummy cycle, no bus access, then READ.
  - READ: o_bus_addr={page,index}, o_bus_rnw=1.
    - On i_cpu_ce, latch i_bus_data_in into the data latch, then go to WRITE.
  - WRITE: o_bus_addr=OAM_DATA_ADDR, o_bus_rnw=0, o_bus_data_out=data latch.
    - On i_cpu_ce, if index==8'hFF: pulse o_done and go to IDLE.
    - Otherwise increment index (8-bit) and go to READ.
- Output encoding:
  - o_cpu_rdy is 0 and o_dma_active is 1 in HALT, ALIGN, READ and WRITE.
  - o_bus_own is 1 only in READ and WRITE.
  - In HALT, ALIGN and IDLE: o_bus_addr=0, o_bus_rnw=1.
  - All outputs are registered, or decoded directly from registered state with no input-to-output combinational path.
- Latency: trigger cycle N, then HALT at N+1, then 512 transfer cycles. Total DMA is 513 CPU cycles when no ALIGN occurs and 514 when ALIGN occurs.
- Index wraps only via termination; the source address never crosses the page (page $FF reads $FF00-$FFFF).
- When i_cpu_ce is low, everything holds.
- Reset deasserted mid-page: the block restarts cleanly in IDLE with no partial resume.

Test Plan:
- Reset values: hold i_reset_n=0 for 3 clocks -> o_cpu_rdy=1, o_bus_own=0, o_bus_addr=0, o_bus_rnw=1, o_dma_active=0.
- Aligned DMA: write $02 to $4014 with parity after trigger such that HALT sees parity=1; memory $0200+i = i^8'h5A -> 513 cycles of o_cpu_rdy=0; 256 writes to $2004 with data i^8'h5A in order; o_done pulses once; o_cpu_rdy=1 on the next cycle.
- Misaligned DMA: same with opposite parity -> exactly one ALIGN cycle with o_bus_own=0; total 514 cycles of o_cpu_rdy=0; first READ address $0200.
- Page $FF: trigger with $FF -> last read address $FFFF, then a write to $2004, then IDLE; no access to $0000.
- Retrigger ignored: write $07 to $4014 at transfer 100 -> remaining reads still use page $02; total cycle count unchanged.
- Reset mid-DMA: assert i_reset_n=0 at transfer 37 -> o_cpu_rdy=1 and o_bus_own=0 asynchronously; after release, a new trigger with $03 starts from $0300.
- i_cpu_ce gaps: insert 0-3 idle clocks between i_cpu_ce pulses -> identical bus sequence and cycle counts measured in i_cpu_ce pulses.
